// File: rtl/code_qualify_decoder.sv
// Debounce/qualify stage behind the 8-to-3 coder: accepts a code after STABLE_CYCLES matching samples
// and delivers it as a one-hot byte on valid/ready. Optional glitch counter: define GLITCH_CNT_EN.
module code_qualify_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    input  logic             in_valid,
    output logic [7:0]       z,
    output logic             z_valid,
    input  logic             z_ready,
    output logic [EVT_W-1:0] evt_count
`ifdef GLITCH_CNT_EN
    ,
    output logic [EVT_W-1:0] glitch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        HOLD,
        RELEASE
    } state_t;

    localparam bit ACCEPT_NOW = (STABLE_CYCLES == 1);

    state_t           state, state_n;
    logic [2:0]       code;
    logic [2:0]       cand, cand_n;
    logic [3:0]       cnt, cnt_n;
    logic [4:0]       cnt_inc;
    logic [7:0]       z_n;
    logic             z_valid_n;
    logic [EVT_W-1:0] evt_n;

    function automatic logic [7:0] onehot(input logic [2:0] c);
        onehot = 8'(1) << c;
    endfunction

    assign code    = {y3, y2, y1};
    assign cnt_inc = {1'b0, cnt} + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            z         <= '0;
            z_valid   <= 1'b0;
            evt_count <= '0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            z         <= z_n;
            z_valid   <= z_valid_n;
            evt_count <= evt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        z_n       = z;
        z_valid_n = z_valid;
        evt_n     = evt_count;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    cand_n = code;
                    cnt_n  = 4'd1;
                    if (ACCEPT_NOW) begin
                        z_n       = onehot(code);
                        z_valid_n = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        state_n = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (!in_valid) begin
                    state_n = IDLE;
                end else if (code != cand) begin
                    cand_n = code;
                    cnt_n  = 4'd1;
                end else begin
                    cnt_n = cnt_inc[3:0];
                    if (cnt_inc >= 5'(STABLE_CYCLES)) begin
                        z_n       = onehot(cand);
                        z_valid_n = 1'b1;
                        state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (z_valid && z_ready) begin
                    z_n       = '0;
                    z_valid_n = 1'b0;
                    evt_n     = evt_count + EVT_W'(1);
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                if (!in_valid) begin
                    state_n = IDLE;
                end else if (code != cand) begin
                    cand_n = code;
                    cnt_n  = 4'd1;
                    // A single required sample is already satisfied by this edge, as from IDLE.
                    if (ACCEPT_NOW) begin
                        z_n       = onehot(code);
                        z_valid_n = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        state_n = QUALIFY;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef GLITCH_CNT_EN
    logic glitch;

    assign glitch = (state == QUALIFY) && (!in_valid || (code != cand));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_count <= '0;
        end else if (glitch && (glitch_count != '1)) begin
            glitch_count <= glitch_count + EVT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_code_qualify_decoder.sv
// Scoreboard bench for code_qualify_decoder: one instance at default parameters, one with
// STABLE_CYCLES=1 / EVT_W=2 for the single-sample and counter-wrap cases.
module tb_code_qualify_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] code_a, code_b;
    logic       in_valid_a, in_valid_b, z_ready_a, z_ready_b;
    logic [7:0] z_a, z_b;
    logic       zv_a, zv_b;
    logic [7:0] evt_a;
    logic [1:0] evt_b;
`ifdef GLITCH_CNT_EN
    logic [7:0] glitch_a;
    logic [1:0] glitch_b;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    code_qualify_decoder #(.STABLE_CYCLES(4), .EVT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .y1(code_a[0]), .y2(code_a[1]), .y3(code_a[2]),
        .in_valid(in_valid_a),
        .z(z_a), .z_valid(zv_a), .z_ready(z_ready_a),
        .evt_count(evt_a)
`ifdef GLITCH_CNT_EN
        , .glitch_count(glitch_a)
`endif
    );

    code_qualify_decoder #(.STABLE_CYCLES(1), .EVT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .y1(code_b[0]), .y2(code_b[1]), .y3(code_b[2]),
        .in_valid(in_valid_b),
        .z(z_b), .z_valid(zv_b), .z_ready(z_ready_b),
        .evt_count(evt_b)
`ifdef GLITCH_CNT_EN
        , .glitch_count(glitch_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: pop the scoreboard on every completed handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (zv_a) begin
                check("a_onehot", $countones(z_a), 1);
                if (z_ready_a) begin
                    if (exp_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected_delivery: got z=%0h, required no delivery", z_a);
                    end else begin
                        check("a_delivered_z", z_a, exp_a.pop_front());
                    end
                end
            end else begin
                check("a_idle_z_zero", z_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (zv_b) begin
                check("b_onehot", $countones(z_b), 1);
                if (z_ready_b) begin
                    if (exp_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected_delivery: got z=%0h, required no delivery", z_b);
                    end else begin
                        check("b_delivered_z", z_b, exp_b.pop_front());
                    end
                end
            end else begin
                check("b_idle_z_zero", z_b, 0);
            end
        end
    end

    logic [2:0] codes_b [4] = '{3'd0, 3'd3, 3'd4, 3'd7};
    logic [7:0] zexp_b  [4] = '{8'h01, 8'h08, 8'h10, 8'h80};
    logic [1:0] evtexp_b[4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst_n      = 1'b0;
        code_a     = 3'b111;
        in_valid_a = 1'b1;
        z_ready_a  = 1'b0;
        code_b     = 3'b000;
        in_valid_b = 1'b0;
        z_ready_b  = 1'b1;

        // Reset with an active input
        tick(2);
        check("rst_z", z_a, 0);
        check("rst_z_valid", zv_a, 0);
        check("rst_evt", evt_a, 0);
        check("rst_b_evt", evt_b, 0);
`ifdef GLITCH_CNT_EN
        check("rst_glitch", glitch_a, 0);
`endif
        rst_n = 1'b1;
        tick(3);
        check("t1_not_yet", zv_a, 0);
        exp_a.push_back(8'h80);
        tick(1);
        check("t1_valid", zv_a, 1);
        check("t1_z", z_a, 8'h80);
        z_ready_a = 1'b1;
        tick(1);
        check("t1_drop", zv_a, 0);
        check("t1_evt", evt_a, 1);

        // Basic acceptance of 101
        in_valid_a = 1'b0;
        tick(1);
        code_a     = 3'b101;
        in_valid_a = 1'b1;
        tick(3);
        check("t2_not_yet", zv_a, 0);
        exp_a.push_back(8'h20);
        tick(1);
        check("t2_valid", zv_a, 1);
        check("t2_z", z_a, 8'h20);
        tick(1);
        check("t2_one_cycle", zv_a, 0);
        check("t2_evt", evt_a, 2);
        tick(6);
        check("t2_no_redeliver", zv_a, 0);
        check("t2_evt_held", evt_a, 2);

        // Bounce: 011 for two edges, then 110
        in_valid_a = 1'b0;
        tick(1);
        code_a     = 3'b011;
        in_valid_a = 1'b1;
        tick(2);
        code_a = 3'b110;
        tick(1);
        check("t3_after_glitch", zv_a, 0);
`ifdef GLITCH_CNT_EN
        check("t3_glitch", glitch_a, 1);
`endif
        tick(2);
        check("t3_not_yet", zv_a, 0);
        exp_a.push_back(8'h40);
        tick(1);
        check("t3_valid", zv_a, 1);
        check("t3_z", z_a, 8'h40);
        tick(1);
        check("t3_evt", evt_a, 3);

        // Backpressure with input change during HOLD
        in_valid_a = 1'b0;
        tick(1);
        z_ready_a  = 1'b0;
        code_a     = 3'b101;
        in_valid_a = 1'b1;
        exp_a.push_back(8'h20);
        tick(4);
        check("t4_valid", zv_a, 1);
        check("t4_z", z_a, 8'h20);
        code_a = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t4_hold_z", z_a, 8'h20);
            check("t4_hold_valid", zv_a, 1);
        end
        exp_a.push_back(8'h04);
        z_ready_a = 1'b1;
        tick(1);
        check("t4_handshake", zv_a, 0);
        check("t4_evt", evt_a, 4);
        tick(3);
        check("t4_new_not_yet", zv_a, 0);
        tick(1);
        check("t4_new_valid", zv_a, 1);
        check("t4_new_z", z_a, 8'h04);
        tick(1);
        check("t4_evt2", evt_a, 5);
`ifdef GLITCH_CNT_EN
        check("t4_glitch", glitch_a, 1);
`endif

        // Reset while holding an undelivered code
        in_valid_a = 1'b0;
        tick(1);
        z_ready_a  = 1'b0;
        code_a     = 3'b111;
        in_valid_a = 1'b1;
        tick(4);
        check("t5_hold", zv_a, 1);
        rst_n = 1'b0;
        tick(1);
        check("t5_rst_valid", zv_a, 0);
        check("t5_rst_z", z_a, 0);
        check("t5_rst_evt", evt_a, 0);
`ifdef GLITCH_CNT_EN
        check("t5_rst_glitch", glitch_a, 0);
`endif
        rst_n      = 1'b1;
        in_valid_a = 1'b0;
        tick(1);
        check("t5_after_valid", zv_a, 0);
        check("t5_after_evt", evt_a, 0);

        // STABLE_CYCLES=1 and 2-bit counter wrap
        for (int i = 0; i < 4; i++) begin
            code_b     = codes_b[i];
            in_valid_b = 1'b1;
            exp_b.push_back(zexp_b[i]);
            tick(1);
            check("t6_valid", zv_b, 1);
            check("t6_z", z_b, zexp_b[i]);
            tick(1);
            check("t6_evt", evt_b, evtexp_b[i]);
            check("t6_drop", zv_b, 0);
            in_valid_b = 1'b0;
            tick(1);
        end

        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
